logic_op_unit: RTL and testbench



---
 rtl/logic_op_unit.sv | 119 +++++++++++
 tb/tb_logic_op_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/logic_op_unit.sv
// WIDTH-bit registered bitwise logic unit: eight ops, valid/ready in and out,
// optional accumulate mode that folds each beat's result into a running value.
module logic_op_unit #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  input  logic               mode,
  input  logic               acc_clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  output logic               y_zero,
  output logic               y_ones,
  output logic [COUNT_W-1:0] beat_cnt
);

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               y_zero_q, y_zero_d;
  logic               y_ones_q, y_ones_d;
  logic [COUNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               acc_empty_q, acc_empty_d;

  logic               accept;
  logic               acc_empty_eff;
  logic [WIDTH-1:0]   left;
  logic [WIDTH-1:0]   result;

  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // A same-cycle clear takes effect before the beat picks its left operand.
  assign acc_empty_eff = acc_clear || acc_empty_q;
  assign left          = (mode && !acc_empty_eff) ? acc_q : a;

  always_comb begin
    result = '0;
    unique case (op)
      3'b000: result = left & b;
      3'b001: result = left | b;
      3'b010: result = left ^ b;
      3'b011: result = ~(left & b);
      3'b100: result = ~(left | b);
      3'b101: result = ~(left ^ b);
      3'b110: result = left;
      3'b111: result = ~left;
      default: result = '0;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    y_zero_d    = y_zero_q;
    y_ones_d    = y_ones_q;
    beat_cnt_d  = beat_cnt_q;
    acc_d       = acc_q;
    acc_empty_d = acc_empty_q;

    if (accept) begin
      out_valid_d = 1'b1;
      y_d         = result;
      y_zero_d    = (result == '0);
      y_ones_d    = &result;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (acc_clear) begin
      acc_d       = '0;
      acc_empty_d = 1'b1;
    end
    if (accept && mode) begin
      acc_d       = result;
      acc_empty_d = 1'b0;
    end

    if (acc_clear) begin
      beat_cnt_d = accept ? COUNT_W'(1) : '0;
    end else if (accept && !(&beat_cnt_q)) begin
      beat_cnt_d = beat_cnt_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      y_zero_q    <= 1'b0;
      y_ones_q    <= 1'b0;
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      acc_empty_q <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      y_zero_q    <= y_zero_d;
      y_ones_q    <= y_ones_d;
      beat_cnt_q  <= beat_cnt_d;
      acc_q       <= acc_d;
      acc_empty_q <= acc_empty_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign y_zero    = y_zero_q;
  assign y_ones    = y_ones_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_logic_op_unit.sv
// Directed-vector bench for logic_op_unit; a second instance with COUNT_W=3
// shares the stimulus so counter saturation can be observed.
module tb_logic_op_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       mode;
  logic       acc_clear;
  logic       out_ready;

  logic       in_ready, out_valid, y_zero, y_ones;
  logic [7:0] y, beat_cnt;
  logic       in_ready3, out_valid3, y_zero3, y_ones3;
  logic [7:0] y3;
  logic [2:0] beat_cnt3;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  logic_op_unit #(.WIDTH(8), .COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .mode(mode), .acc_clear(acc_clear),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .y_zero(y_zero), .y_ones(y_ones), .beat_cnt(beat_cnt)
  );

  logic_op_unit #(.WIDTH(8), .COUNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .a(a), .b(b), .op(op), .mode(mode), .acc_clear(acc_clear),
    .out_valid(out_valid3), .out_ready(out_ready), .y(y3),
    .y_zero(y_zero3), .y_ones(y_ones3), .beat_cnt(beat_cnt3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input logic [2:0] o,
                       input logic [7:0] av, input logic [7:0] bv);
    in_valid = v; mode = m; op = o; a = av; b = bv;
  endtask

  logic [7:0] op_exp [8];

  initial begin
    op_exp = '{8'h81, 8'hE7, 8'h66, 8'h7E, 8'h18, 8'h99, 8'hC3, 8'h3C};
    rst = 1'b1; acc_clear = 1'b0; out_ready = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    step(); step();
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst y", 32'(y), 32'h0);
    check("rst y_zero", 32'(y_zero), 32'h0);
    check("rst beat_cnt", 32'(beat_cnt), 32'h0);
    check("rst in_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;

    // All eight ops back to back
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 3'(i), 8'hC3, 8'hA5);
      #1 check($sformatf("op%0d in_ready", i), 32'(in_ready), 32'h1);
      step();
      check($sformatf("op%0d y", i), 32'(y), 32'(op_exp[i]));
      check($sformatf("op%0d out_valid", i), 32'(out_valid), 32'h1);
    end
    check("ops beat_cnt", 32'(beat_cnt), 32'd8);

    // Backpressure
    drive(1'b1, 1'b0, 3'd1, 8'hC3, 8'hA5);
    step();
    check("bp first y", 32'(y), 32'hE7);
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 3'd2, 8'hC3, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      #1 check($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'h0);
      step();
      check($sformatf("bp%0d y held", i), 32'(y), 32'hE7);
      check($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'h1);
    end
    check("bp beat_cnt held", 32'(beat_cnt), 32'd9);
    out_ready = 1'b1;
    #1 check("bp release in_ready", 32'(in_ready), 32'h1);
    step();
    check("bp next y", 32'(y), 32'h66);
    check("bp beat_cnt", 32'(beat_cnt), 32'd10);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    step();
    check("drain out_valid", 32'(out_valid), 32'h0);
    check("drain y kept", 32'(y), 32'h66);

    // Async reset while a result is pending
    drive(1'b1, 1'b1, 3'd0, 8'hFF, 8'hFF);
    step();
    check("pre-rst y", 32'(y), 32'hFF);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check("async rst out_valid", 32'(out_valid), 32'h0);
    check("async rst y", 32'(y), 32'h0);
    check("async rst beat_cnt", 32'(beat_cnt), 32'h0);
    check("async rst in_ready", 32'(in_ready), 32'h0);
    #1 rst = 1'b0;
    out_ready = 1'b1;

    // Accumulate chain with an interleaved pairwise beat
    drive(1'b1, 1'b1, 3'd2, 8'h0F, 8'h01); step();
    check("acc1 y", 32'(y), 32'h0E);
    drive(1'b1, 1'b1, 3'd2, 8'h0F, 8'h02); step();
    check("acc2 y", 32'(y), 32'h0C);
    drive(1'b1, 1'b1, 3'd2, 8'h0F, 8'h04); step();
    check("acc3 y", 32'(y), 32'h08);
    drive(1'b1, 1'b0, 3'd0, 8'hFF, 8'h00); step();
    check("pair y", 32'(y), 32'h00);
    check("pair y_zero", 32'(y_zero), 32'h1);
    drive(1'b1, 1'b1, 3'd2, 8'h0F, 8'h08); step();
    check("acc4 y", 32'(y), 32'h00);
    check("acc4 y_zero", 32'(y_zero), 32'h1);
    check("acc4 y_ones", 32'(y_ones), 32'h0);
    check("acc beat_cnt", 32'(beat_cnt), 32'd5);

    // Clear colliding with an accepted accumulate beat
    acc_clear = 1'b1;
    drive(1'b1, 1'b1, 3'd0, 8'hF0, 8'hFF); step();
    acc_clear = 1'b0;
    check("clr-hit y", 32'(y), 32'hF0);
    check("clr-hit beat_cnt", 32'(beat_cnt), 32'd1);
    drive(1'b1, 1'b1, 3'd0, 8'h00, 8'h3C); step();
    check("clr-next y", 32'(y), 32'h30);

    // Clear alone, then accumulate restarts from a
    acc_clear = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00); step();
    acc_clear = 1'b0;
    check("clr beat_cnt", 32'(beat_cnt), 32'd0);
    check("clr y kept", 32'(y), 32'h30);
    drive(1'b1, 1'b1, 3'd0, 8'h55, 8'hFF); step();
    check("post-clr y", 32'(y), 32'h55);

    // Saturation on the COUNT_W=3 instance
    acc_clear = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00); step();
    acc_clear = 1'b0;
    check("sat start", 32'(beat_cnt3), 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 3'd1, 8'hFF, 8'h00); step();
      check($sformatf("sat%0d beat_cnt3", i), 32'(beat_cnt3), (i < 7) ? 32'(i + 1) : 32'd7);
      check($sformatf("sat%0d beat_cnt", i), 32'(beat_cnt), 32'(i + 1));
      check($sformatf("sat%0d y_ones", i), 32'(y_ones3), 32'h1);
    end
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
